// File: rtl/conv_layer_stream.sv
// Streaming multi-channel 2-D valid convolution.
// Takes one pre-padded pixel per cycle in raster order. K-1 line buffers and a
// KxK window feed NCH parallel multiply-accumulate trees. The results go to a
// single output register with a valid/ready handshake.
module conv_layer_stream #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 5,
    parameter int NCH    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wt_we,
    input  logic [$clog2(NCH*K*K)-1:0]    wt_addr,
    input  logic signed [DATA_W-1:0]      wt_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NCH*DATA_W-1:0]         out_data,
    output logic                          out_last,
    output logic                          frame_done,
    output logic                          frame_err
);

    localparam int NW    = NCH * K * K;
    localparam int AW    = $clog2(NW);
    localparam int ACC_W = 2 * DATA_W + $clog2(K * K);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t state, state_next;

    logic signed [DATA_W-1:0] weights  [NW];
    logic signed [DATA_W-1:0] line_buf [K-1][IMG_W];
    logic signed [DATA_W-1:0] win      [K][K];
    logic signed [DATA_W-1:0] win_next [K][K];
    logic signed [DATA_W-1:0] new_col  [K];

    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic                     started;
    logic                     accept;
    logic                     at_end;
    logic                     bad_last;
    logic                     produce;
    logic                     flush_done;
    logic [NCH*DATA_W-1:0]    result;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted;

    // started keeps in_ready low for the first cycle after reset release
    assign in_ready   = started && (state != FLUSH) && !(out_valid && !out_ready);
    assign accept     = in_valid && in_ready;
    assign at_end     = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign bad_last   = in_last != at_end;
    assign produce    = (row >= RW'(K - 1)) && (col >= CW'(K - 1));
    assign flush_done = (state == FLUSH) && (!out_valid || (out_ready && out_last));

    // Build the window as it will look after the current pixel shifts in
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            new_col[r] = line_buf[r][col];
        end
        new_col[K-1] = in_data;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_next[r][c] = (c < K - 1) ? win[r][c+1] : new_col[r];
            end
        end
    end

    // Exact per-channel dot product, floor shift by FRAC_W, then saturate
    always_comb begin
        result  = '0;
        prod    = '0;
        acc     = '0;
        shifted = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            acc = '0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    prod = (2*DATA_W)'(win_next[r][c]) * (2*DATA_W)'(weights[ch*K*K + r*K + c]);
                    acc  = acc + ACC_W'(prod);
                end
            end
            shifted = acc >>> FRAC_W;
            if (shifted > SAT_MAX) begin
                result[ch*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
            end else if (shifted < SAT_MIN) begin
                result[ch*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
            end else begin
                result[ch*DATA_W +: DATA_W] = shifted[DATA_W-1:0];
            end
        end
    end

    // Weight memory: writable only between frames; out-of-range addresses are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) weights[i] <= '0;
        end else if (wt_we && (state == IDLE) && ({1'b0, wt_addr} < (AW+1)'(NW))) begin
            weights[wt_addr] <= wt_data;
        end
    end

    // Line buffers roll upward per column: entry 0 holds the oldest row
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K - 2; r++) begin
                line_buf[r][col] <= line_buf[r+1][col];
            end
            line_buf[K-2][col] <= in_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state: a misplaced or missing in_last aborts the frame back to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE, RUN: begin
                if (accept) begin
                    if (bad_last)    state_next = IDLE;
                    else if (at_end) state_next = FLUSH;
                    else             state_next = RUN;
                end
            end
            FLUSH: begin
                if (flush_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, window, output register and status pulses.
    // A pixel that trips frame_err still emits its output if its position
    // completes a window, but that output never carries out_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started    <= 1'b0;
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    win[r][c] <= '0;
        end else begin
            started    <= 1'b1;
            frame_done <= flush_done;
            frame_err  <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (accept) begin
                if (produce) begin
                    out_valid <= 1'b1;
                    out_data  <= result;
                    out_last  <= at_end && in_last;
                end
                if (bad_last) begin
                    frame_err <= 1'b1;
                    col       <= '0;
                    row       <= '0;
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            win[r][c] <= '0;
                end else begin
                    win <= win_next;
                    if (col == CW'(IMG_W - 1)) begin
                        col <= '0;
                        row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_stream.sv
// Scoreboard bench for conv_layer_stream on a 6x6 frame with a 3x3 kernel.
// Instance a uses FRAC_W=0; instance b uses FRAC_W=8 for the rounding case.
// Both instances share the stimulus buses, and sel chooses which one is active.
module tb_conv_layer_stream;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, sel;
    logic              wt_we, in_valid, in_last, out_ready;
    logic [4:0]        wt_addr;
    logic signed [15:0] wt_data, in_data;

    logic        in_ready_a, out_valid_a, out_last_a, frame_done_a, frame_err_a;
    logic        in_ready_b, out_valid_b, out_last_b, frame_done_b, frame_err_b;
    logic [31:0] out_data_a, out_data_b;

    logic        in_ready, out_valid, out_last, frame_done, frame_err;
    logic [31:0] out_data;

    assign in_ready   = sel ? in_ready_b   : in_ready_a;
    assign out_valid  = sel ? out_valid_b  : out_valid_a;
    assign out_last   = sel ? out_last_b   : out_last_a;
    assign out_data   = sel ? out_data_b   : out_data_a;
    assign frame_done = sel ? frame_done_b : frame_done_a;
    assign frame_err  = sel ? frame_err_b  : frame_err_a;

    conv_layer_stream #(.DATA_W(DW), .FRAC_W(0), .IMG_W(6), .IMG_H(6), .K(3), .NCH(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .wt_we(wt_we && !sel), .wt_addr(wt_addr), .wt_data(wt_data),
        .in_valid(in_valid && !sel), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_last(out_last_a),
        .frame_done(frame_done_a), .frame_err(frame_err_a)
    );

    conv_layer_stream #(.DATA_W(DW), .FRAC_W(8), .IMG_W(6), .IMG_H(6), .K(3), .NCH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .wt_we(wt_we && sel), .wt_addr(wt_addr), .wt_data(wt_data),
        .in_valid(in_valid && sel), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b),
        .frame_done(frame_done_b), .frame_err(frame_err_b)
    );

    typedef struct {
        logic signed [15:0] c0;
        logic signed [15:0] c1;
        logic               last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   err_seen = 0;
    logic last_hs_prev = 1'b0;
    logic stall_prev = 1'b0;
    logic [31:0] held_data;
    logic        held_last;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks held data during stalls
    always @(negedge clk) begin
        if (!rst_n) begin
            last_hs_prev = 1'b0;
            stall_prev   = 1'b0;
        end else begin
            if (last_hs_prev) checkOutput("frame_done_after_last", frame_done, 1);
            last_hs_prev = 1'b0;
            if (frame_done) done_seen++;
            if (frame_err) err_seen++;
            if (out_valid && !out_ready) begin
                if (stall_prev) begin
                    checkOutput("held_data", out_data, held_data);
                    checkOutput("held_last", out_last, held_last);
                end
                checkOutput("in_ready_during_stall", in_ready, 0);
                held_data  = out_data;
                held_last  = out_last;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got data %h, expected none", out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("out_ch0", $signed(out_data[15:0]), e.c0);
                    checkOutput("out_ch1", $signed(out_data[31:16]), e.c1);
                    checkOutput("out_last", out_last, e.last);
                    if (e.last) last_hs_prev = 1'b1;
                end
            end
        end
    end

    task automatic writeWeight(input int addr, input int val);
        wt_we   = 1'b1;
        wt_addr = addr[4:0];
        wt_data = val[15:0];
        @(posedge clk);
        #1;
        wt_we = 1'b0;
    endtask

    task automatic sendPixel(input int v, input logic last);
        int   n;
        logic done;
        n        = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = v[15:0];
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: pixel %0d not accepted, expected acceptance", v);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // kind 0: pixel value equals its raster index (row*6+col); kind 1: constant cval
    task automatic applyStimulus(input int kind, input int cval, input int first,
                                 input int count, input int last_at);
        for (int i = first; i < first + count; i++) begin
            sendPixel((kind == 0) ? i : cval, i == last_at);
        end
    endtask

    // Ramp frame, ch0 box-sum and ch1 centre tap: the window at output (r,c)
    // is centred on pixel 6(r+1)+(c+1), so ch0 = 9*(6r+c+7) and ch1 = 6r+c+7
    task automatic expectRamp(input int nrows, input int ncols, input logic final_last);
        exp_t e;
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < ncols; c++) begin
                e.c0   = 16'(9 * (6 * r + c + 7));
                e.c1   = 16'(6 * r + c + 7);
                e.last = final_last && (r == 3) && (c == 3);
                sb.push_back(e);
            end
        end
    endtask

    task automatic expectConst(input int c0, input int c1);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.c0   = c0[15:0];
            e.c1   = c1[15:0];
            e.last = (i == 15);
            sb.push_back(e);
        end
    endtask

    task automatic loadRampWeights();
        for (int i = 0; i < 9; i++) writeWeight(i, 1);
        for (int i = 0; i < 9; i++) writeWeight(9 + i, (i == 4) ? 1 : 0);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d outputs outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        sel = 1'b0; rst_n = 1'b0; out_ready = 1'b1;
        wt_we = 1'b0; wt_addr = '0; wt_data = '0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        #1;
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("in_ready_first_cycle", in_ready, 0);
        @(posedge clk); #1;
        checkOutput("in_ready_after_reset", in_ready, 1);

        $display("[TB] basic ramp frame");
        loadRampWeights();
        expectRamp(4, 4, 1'b1);
        applyStimulus(0, 0, 0, 36, 35);
        waitDrain();

        $display("[TB] output stall");
        expectRamp(4, 4, 1'b1);
        fork
            applyStimulus(0, 0, 0, 36, 35);
            begin
                repeat (16) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] saturation");
        for (int i = 0; i < 9; i++) writeWeight(i, 32767);
        for (int i = 0; i < 9; i++) writeWeight(9 + i, -32768);
        expectConst(32767, -32768);
        applyStimulus(1, 32767, 0, 36, 35);
        waitDrain();

        $display("[TB] fractional floor");
        sel = 1'b1;
        writeWeight(4, 16'h0080);
        writeWeight(13, 16'h0180);
        expectConst(-2, -5);
        applyStimulus(1, -3, 0, 36, 35);
        waitDrain();
        sel = 1'b0;

        $display("[TB] early in_last and ignored weight write");
        loadRampWeights();
        expectRamp(1, 4, 1'b0);
        begin
            exp_t e;
            e.c0 = 16'sd117; e.c1 = 16'sd13; e.last = 1'b0;
            sb.push_back(e);
        end
        applyStimulus(0, 0, 0, 6, -1);
        writeWeight(0, 100);
        applyStimulus(0, 0, 6, 15, 20);
        waitDrain();
        expectRamp(4, 4, 1'b1);
        applyStimulus(0, 0, 0, 36, 35);
        waitDrain();

        $display("[TB] reset mid-frame");
        expectRamp(1, 3, 1'b0);
        applyStimulus(0, 0, 0, 17, -1);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pending_before_reset", out_valid, 1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_in_ready", in_ready, 0);
        checkOutput("midreset_out_data", out_data, 0);
        checkOutput("midreset_out_last", out_last, 0);
        checkOutput("midreset_frame_done", frame_done, 0);
        checkOutput("midreset_frame_err", frame_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        checkOutput("in_ready_first_cycle_2", in_ready, 0);
        @(posedge clk); #1;
        checkOutput("in_ready_after_reset_2", in_ready, 1);
        expectConst(0, 0);
        applyStimulus(1, 5, 0, 36, 35);
        waitDrain();

        checkOutput("frame_done_count", done_seen, 6);
        checkOutput("frame_err_count", err_seen, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
